// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the HEX display controller slice.
// Provides the per-digit mode encodings, the segment fill patterns and the
// arbiter owner type used by the round-robin arbiter.
package hex_disp_pkg;

  localparam logic [1:0] MODE_SHOW  = 2'b00;
  localparam logic [1:0] MODE_BLANK = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  // 2'b11 is reserved and displays like MODE_SHOW

  localparam logic [6:0] SEG_BLANK = 7'h7F;  // active-low: all segments off
  localparam logic [6:0] SEG_ALL   = 7'h00;  // active-low: all segments on

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Write-request bus shared by the two requesters of hex_display_ctrl.
//   req_valid[i]        request from port i
//   req_ready[i]        grant to port i (transfer when valid & ready)
//   req_digit[3*i+:3]   target digit index of port i
//   req_value[4*i+:4]   hex value of port i
//   req_mode[2*i+:2]    display mode of port i
interface hex_display_ctrl_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_digit;
  logic [7:0] req_value;
  logic [3:0] req_mode;

  modport master (
    output req_valid, req_digit, req_value, req_mode,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_digit, req_value, req_mode,
    output req_ready
  );
endinterface

// File: rtl/hex7seg.sv
// Hex to seven-segment decoder, active-low outputs.
//   i_value  4-bit hex value
//   o_seg    segments, bit k = segment k (0 top .. 6 middle), 0 = lit
module hex7seg (
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_value)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0011000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst   clock and synchronous active-high reset
//   i_valid    request per port
//   o_grant    one-hot (or zero) grant, combinational, zero during reset
//   o_sel      index of the granted port (meaningful when |o_grant)
module rr_arb2
  import hex_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant,
  output logic       o_sel
);
  port_e r_last;
  port_e w_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_last <= PORT1;  // port 0 wins the first contention
    else     r_last <= w_last_nxt;
  end

  always_comb begin
    o_grant    = '0;
    o_sel      = 1'b0;
    w_last_nxt = r_last;
    if (!rst) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (r_last == PORT0) ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
    o_sel = o_grant[1];
    // Owner only moves on an actual transfer
    if (|o_grant) w_last_nxt = o_sel ? PORT1 : PORT0;
  end
endmodule

// File: rtl/hex_display_ctrl.sv
// Shared controller for a bank of seven-segment HEX displays.
// Two requesters write per-digit value/mode through a round-robin arbitrated
// valid/ready bus; a free-running prescaler drives the blink phase and every
// digit gets a registered active-low segment pattern.
//   clk, rst  clock and synchronous active-high reset
//   bus       write-request bus (slave side)
//   test_en   lamp test, all segments lit one cycle after assertion
//   hex_out   active-low segments, digit d at [7*d+:7]
//   err       sticky flag: a write targeted a digit >= NUM_DIGITS
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_display_ctrl_if.slave       bus,
  input  logic                    test_en,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    err
);
  localparam int         CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] ND    = 4'(NUM_DIGITS);

  logic [1:0] w_grant;
  logic       w_sel;
  logic       w_xfer;
  logic [2:0] w_digit;
  logic [3:0] w_value;
  logic [1:0] w_mode;
  logic       w_in_range;

  logic [3:0]             r_value [NUM_DIGITS];
  logic [1:0]             r_mode  [NUM_DIGITS];
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_phase;
  logic                   r_err;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [6:0]             w_seg   [NUM_DIGITS];
  logic [6:0]             w_disp  [NUM_DIGITS];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.req_valid),
    .o_grant (w_grant),
    .o_sel   (w_sel)
  );

  assign bus.req_ready = w_grant;
  assign w_xfer        = |w_grant;
  assign w_digit       = w_sel ? bus.req_digit[5:3] : bus.req_digit[2:0];
  assign w_value       = w_sel ? bus.req_value[7:4] : bus.req_value[3:0];
  assign w_mode        = w_sel ? bus.req_mode[3:2]  : bus.req_mode[1:0];
  assign w_in_range    = ({1'b0, w_digit} < ND);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        r_value[d] <= '0;
        r_mode[d]  <= MODE_BLANK;
      end
      r_err <= 1'b0;
    end else if (w_xfer) begin
      if (w_in_range) begin
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
          if (w_digit == 3'(d)) begin
            r_value[d] <= w_value;
            r_mode[d]  <= w_mode;
          end
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex7seg u_dec (
        .i_value (r_value[g]),
        .o_seg   (w_seg[g])
      );
    end
  endgenerate

  always_comb begin
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      w_disp[d] = w_seg[d];
      if (test_en)                                  w_disp[d] = SEG_ALL;
      else if (r_mode[d] == MODE_BLANK)             w_disp[d] = SEG_BLANK;
      else if (r_mode[d] == MODE_BLINK && r_phase)  w_disp[d] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hex <= '1;
    end else begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        r_hex[7*d +: 7] <= w_disp[d];
      end
    end
  end

  assign hex_out = r_hex;
  assign err     = r_err;
endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          test_en;
  logic [7*ND-1:0] hex_out;
  logic          err;

  hex_display_ctrl_if bus();

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .test_en (test_en),
    .hex_out (hex_out),
    .err     (err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0]      m_val  [ND];
  logic [1:0]      m_mode [ND];
  int              m_last;     // index of last granted port
  int              m_n;        // clock edges since reset
  bit              m_err;
  logic [7*ND-1:0] m_hex;
  logic [6:0]      seg_tab [16];

  typedef struct {
    logic [1:0] v;
    logic [5:0] dg;
    logic [7:0] vl;
    logic [3:0] md;
    bit         te;
    logic [1:0] exp_rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_digit(input int d, input bit te);
    bit phase;
    phase = ((m_n / BD) % 2) == 1;
    if (te)                                 return 7'b0000000;
    if (m_mode[d] == 2'b01)                 return 7'b1111111;
    if (m_mode[d] == 2'b10 && phase)        return 7'b1111111;
    return seg_tab[m_val[d]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_val[d]  = 4'h0;
      m_mode[d] = 2'b01;
    end
    m_last = 1;
    m_n    = 0;
    m_err  = 0;
    m_hex  = '1;
  endtask

  // One clock cycle: drive, check grant, advance model, check registered outputs.
  task automatic step(input logic [1:0] v, input logic [5:0] dg, input logic [7:0] vl,
                      input logic [3:0] md, input bit te, input bit r,
                      output logic [1:0] act_rdy);
    logic [1:0]      gr;
    logic [7*ND-1:0] nh;
    int              p;
    int              dig;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_digit = dg;
    bus.req_value = vl;
    bus.req_mode  = md;
    test_en       = te;
    rst           = r;
    #1;
    if (r)            gr = 2'b00;
    else if (v == 2'b01) gr = 2'b01;
    else if (v == 2'b10) gr = 2'b10;
    else if (v == 2'b11) gr = (m_last == 0) ? 2'b10 : 2'b01;
    else              gr = 2'b00;
    act_rdy = bus.req_ready;
    check("req_ready", {62'd0, bus.req_ready}, {62'd0, gr});
    for (int d = 0; d < ND; d++) nh[7*d +: 7] = ref_digit(d, te);
    if (r) begin
      model_reset();
    end else begin
      if (gr != 2'b00) begin
        p   = gr[1] ? 1 : 0;
        dig = int'(dg[3*p +: 3]);
        if (dig < ND) begin
          m_val[dig]  = vl[4*p +: 4];
          m_mode[dig] = md[2*p +: 2];
        end else begin
          m_err = 1;
        end
        m_last = p;
      end
      m_hex = nh;
      m_n++;
    end
    @(posedge clk);
    #1;
    check("hex_out", {22'd0, hex_out}, {22'd0, m_hex});
    check("err", {63'd0, err}, {63'd0, m_err});
  endtask

  task automatic idle(input int n);
    logic [1:0] rd;
    for (int i = 0; i < n; i++) step(2'b00, 6'd0, 8'd0, 4'd0, 1'b0, 1'b0, rd);
  endtask

  logic [1:0] rdy;

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    bus.req_valid = '0;
    bus.req_digit = '0;
    bus.req_value = '0;
    bus.req_mode  = '0;
    test_en       = 1'b0;
    rst           = 1'b1;
    model_reset();

    // Reset release, nothing requested
    step(2'b00, 6'd0, 8'd0, 4'd0, 1'b0, 1'b1, rdy);
    step(2'b00, 6'd0, 8'd0, 4'd0, 1'b0, 1'b1, rdy);
    idle(1);
    check("reset_hex", {22'd0, hex_out}, {22'd0, {(7*ND){1'b1}}});
    check("reset_ready", {62'd0, bus.req_ready}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);

    // Port 0 writes digit 2 = A, visible two cycles later
    step(2'b01, {3'd0, 3'd2}, {4'h0, 4'hA}, {2'b00, 2'b00}, 1'b0, 1'b0, rdy);
    check("wr_grant_p0", {62'd0, rdy}, 64'd1);
    idle(1);
    check("digit2_A", {57'd0, hex_out[20:14]}, {57'd0, 7'b0001000});
    check("digit0_blank", {57'd0, hex_out[6:0]}, {57'd0, 7'b1111111});
    check("digit5_blank", {57'd0, hex_out[41:35]}, {57'd0, 7'b1111111});

    // Table: arbitration sequences and assorted modes
    tbl.push_back('{2'b10, {3'd3, 3'd0}, {4'h5, 4'h0}, {2'b00, 2'b00}, 1'b0, 2'b10});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{2'b11, {3'd1, 3'd0}, {4'h2, 4'h1}, {2'b00, 2'b00}, 1'b0,
                      (i % 2 == 0) ? 2'b01 : 2'b10});
    tbl.push_back('{2'b01, {3'd0, 3'd2}, {4'h0, 4'h7}, {2'b00, 2'b01}, 1'b0, 2'b01});
    tbl.push_back('{2'b10, {3'd4, 3'd0}, {4'hC, 4'h0}, {2'b11, 2'b00}, 1'b0, 2'b10});
    tbl.push_back('{2'b11, {3'd5, 3'd3}, {4'hE, 4'hD}, {2'b00, 2'b00}, 1'b0, 2'b01});
    tbl.push_back('{2'b00, 6'd0, 8'd0, 4'd0, 1'b0, 2'b00});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].dg, tbl[i].vl, tbl[i].md, tbl[i].te, 1'b0, rdy);
      check($sformatf("tbl_ready[%0d]", i), {62'd0, rdy}, {62'd0, tbl[i].exp_rdy});
    end
    idle(1);
    check("digit4_C_reserved", {57'd0, hex_out[34:28]}, {57'd0, 7'b1000110});

    // Blink after a fresh reset: visible in phase 0 first
    step(2'b00, 6'd0, 8'd0, 4'd0, 1'b0, 1'b1, rdy);
    step(2'b01, {3'd0, 3'd0}, {4'h0, 4'h8}, {2'b00, 2'b10}, 1'b0, 1'b0, rdy);
    idle(1);
    check("blink_vis", {57'd0, hex_out[6:0]}, {57'd0, 7'b0000000});
    idle(3);
    check("blink_off", {57'd0, hex_out[6:0]}, {57'd0, 7'b1111111});
    idle(4);
    check("blink_vis2", {57'd0, hex_out[6:0]}, {57'd0, 7'b0000000});
    idle(10);

    // Out-of-range write sets sticky err; reset clears it
    step(2'b10, {3'd7, 3'd0}, {4'h3, 4'h0}, {2'b00, 2'b00}, 1'b0, 1'b0, rdy);
    check("oor_grant", {62'd0, rdy}, 64'd2);
    check("oor_err", {63'd0, err}, 64'd1);
    idle(3);
    check("oor_err_sticky", {63'd0, err}, 64'd1);

    // Lamp test over mixed modes
    step(2'b01, {3'd0, 3'd1}, {4'h0, 4'h9}, {2'b00, 2'b00}, 1'b0, 1'b0, rdy);
    step(2'b10, {3'd3, 3'd0}, {4'h6, 4'h0}, {2'b01, 2'b00}, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 6'd0, 8'd0, 4'd0, 1'b1, 1'b0, rdy);
      check("lamp_all_on", {22'd0, hex_out}, 64'd0);
    end
    idle(2);
    check("lamp_restored_d1", {57'd0, hex_out[13:7]}, {57'd0, 7'b0011000});

    // Reset with requests pending: no grant, everything back to idle
    step(2'b11, {3'd1, 3'd2}, 8'h55, 4'd0, 1'b0, 1'b1, rdy);
    check("rst_no_grant", {62'd0, rdy}, 64'd0);
    check("rst_err_clr", {63'd0, err}, 64'd0);
    check("rst_hex", {22'd0, hex_out}, {22'd0, {(7*ND){1'b1}}});

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 6'($urandom), 8'($urandom), 4'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
